sdiv_seq: RTL and testbench

- Sequential signed divider; the inverse operation of the team's combinational signed array multiplier.
- Takes a 2W-bit two's-complement dividend (product-width) and a W-bit two's-complement divisor.
- Returns a W-bit quotient and a W-bit remainder after a fixed number of cycles, using a restoring shift-subtract datapath on magnitudes.
- Sits beside the multiplier in the arithmetic unit and reuses its operand/product widths, so mult→div round trips can be checked directly.

---
 rtl/sdiv_seq.sv | 138 +++++++++++++
 tb/tb_sdiv_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sdiv_seq.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Restoring shift-subtract on magnitudes, with the signs and the range check applied afterwards.
module sdiv_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           dz
);

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [W-1:0] QMAX_POS = W'((1 << (W - 1)) - 1);
  localparam logic [W-1:0] QMAX_NEG = W'(1 << (W - 1));

  state_t state, state_next;

  logic [2*W-1:0] a_l;
  logic [W-1:0]   b_l;
  logic           sa, sb, dz_l, pre_ovf;
  logic [W-1:0]   rem, sh, b_abs;
  logic [CW-1:0]  cnt;

  logic [2*W-1:0] abs_a;
  logic [W-1:0]   abs_b;
  logic [W+1:0]   trial;
  logic [W-1:0]   rem_shifted;
  logic           neg, range_ovf, fix_ovf;

  assign abs_a       = a_l[2*W-1] ? -a_l : a_l;
  assign abs_b       = b_l[W-1] ? -b_l : b_l;
  assign trial       = {1'b0, rem, sh[W-1]} - {2'b00, b_abs};
  assign rem_shifted = {rem[W-2:0], sh[W-1]};
  assign neg         = sa ^ sb;
  assign range_ovf   = neg ? (sh > QMAX_NEG) : (sh > QMAX_POS);
  assign fix_ovf     = pre_ovf | range_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = PREP;
      PREP: state_next = DIV;
      DIV:  if (cnt == CW'(W - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      PREP, DIV, FIX: busy = 1'b1;
      DONE:           done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_l     <= '0;
      b_l     <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      dz_l    <= 1'b0;
      pre_ovf <= 1'b0;
      rem     <= '0;
      sh      <= '0;
      b_abs   <= '0;
      cnt     <= '0;
      q       <= '0;
      r       <= '0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_l <= a;
          b_l <= b;
        end
        PREP: begin
          sa      <= a_l[2*W-1];
          sb      <= b_l[W-1];
          dz_l    <= (b_l == '0);
          pre_ovf <= (b_l == '0) || (abs_a[2*W-1:W] >= abs_b);
          // Without pre-overflow the upper half is below |b|, so the first W steps of a
          // full 2W-step division would only yield zero quotient bits; start from there.
          rem     <= abs_a[2*W-1:W];
          sh      <= abs_a[W-1:0];
          b_abs   <= abs_b;
          cnt     <= '0;
        end
        DIV: begin
          if (!trial[W+1]) begin
            rem <= trial[W-1:0];
            sh  <= {sh[W-2:0], 1'b1};
          end else begin
            rem <= rem_shifted;
            sh  <= {sh[W-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          ovf <= fix_ovf;
          dz  <= dz_l;
          if (fix_ovf) begin
            q <= '0;
            r <= '0;
          end else begin
            q <= neg ? -sh : sh;
            r <= sa ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv_seq.sv
// Bench for sdiv_seq: directed corner cases plus random operands against an integer-division model.
module tb_sdiv_seq;
  localparam int W = 4;
  localparam int RW = 2 * W + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2*W-1:0] a = '0;
  logic [W-1:0]   b = '0;
  logic [W-1:0]   q, r;
  logic           busy, done, ovf, dz;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  sdiv_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {ovf, dz, q, r}, from plain truncating integer division
  function automatic logic [RW-1:0] model(input logic [2*W-1:0] av, input logic [W-1:0] bv);
    int ai, bi, qt, rt;
    ai = int'($signed(av));
    bi = int'($signed(bv));
    if (bi == 0) return {2'b11, {(2*W){1'b0}}};
    qt = ai / bi;
    rt = ai % bi;
    if (qt > (2 ** (W - 1)) - 1 || qt < -(2 ** (W - 1))) return {2'b10, {(2*W){1'b0}}};
    return {2'b00, W'(qt), W'(rt)};
  endfunction

  task automatic run_op(input logic [2*W-1:0] av, input logic [W-1:0] bv, input bit mid_start,
                        output logic [RW-1:0] got);
    int n, busy_cnt;
    logic [RW-1:0] exp;
    exp_q.push_back(model(av, bv));
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; busy_cnt = 0;
    while (!done && n < 30) begin
      if (busy) busy_cnt++;
      if (mid_start && n == 3) begin
        a = 8'($urandom); b = 4'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    got = {ovf, dz, q, r};
    exp = exp_q.pop_front();
    check("timeout", 32'(done), 32'd1);
    check("latency", n, W + 3);
    check("busy_cycles", busy_cnt, W + 2);
    check("result", 32'(got), 32'(exp));
    @(negedge clk);
    check("done_pulse", {busy, done}, 2'b00);
  endtask

  logic [RW-1:0] res;
  int ai, bi, qi, ri;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset", {q, r, busy, done, ovf, dz}, 0);

    run_op(8'h2D, 4'h7, 0, res);
    run_op(8'hD3, 4'h7, 0, res);
    check("neg_a", 32'(res), {2'b00, 4'hA, 4'hD});
    run_op(8'h2D, 4'h9, 0, res);
    check("neg_b", 32'(res), {2'b00, 4'hA, 4'h3});
    run_op(8'hC8, 4'h9, 0, res);
    check("pos_ovf", 32'(res), {2'b10, 8'h00});
    run_op(8'hC8, 4'h7, 0, res);
    check("neg_bound", 32'(res), {2'b00, 4'h8, 4'h0});
    run_op(8'h2D, 4'h0, 0, res);
    check("div_zero", 32'(res), {2'b11, 8'h00});
    run_op(8'h80, 4'hF, 0, res);
    check("min_by_m1", 32'(res), {2'b10, 8'h00});

    // Second start during DIV is ignored; only one done pulse follows
    run_op(8'h2D, 4'h7, 1, res);
    check("mid_start", 32'(res), {2'b00, 4'h6, 4'h3});
    begin
      int extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("no_extra_done", extra, 0);
    end

    // Reset in the middle of DIV aborts the operation
    @(negedge clk);
    a = 8'h2D; b = 4'h7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {q, r, busy, done, ovf, dz}, 0);
    begin
      int extra = 0;
      repeat (10) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("abort_no_done", extra, 0);
    end
    run_op(8'h2D, 4'h7, 0, res);
    check("after_abort", 32'(res), {2'b00, 4'h6, 4'h3});

    for (int i = 0; i < 40; i++) begin
      logic [2*W-1:0] av;
      logic [W-1:0] bv;
      av = 8'($urandom);
      bv = 4'($urandom_range(1, 15));
      run_op(av, bv, 0, res);
      if (!res[RW-1]) begin
        ai = int'($signed(av));
        bi = int'($signed(bv));
        qi = int'($signed(res[2*W-1:W]));
        ri = int'($signed(res[W-1:0]));
        check("recon", qi * bi + ri, ai);
        check("rsign", 32'(ri == 0 || ((ri < 0) == (ai < 0))), 1);
        check("rmag", 32'((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
